// File: rtl/mem_bank_arbiter_if.sv
// Bundle of both request ports and the shared single-port memory pins.
// The "master" modport belongs to the requesters and the memory; the arbiter uses "slave".
`default_nettype none

interface mem_bank_arbiter_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  p0_req,    p1_req;
  logic                  p0_we,     p1_we;
  logic [BE_WIDTH-1:0]   p0_be,     p1_be;
  logic [ADDR_WIDTH-1:0] p0_addr,   p1_addr;
  logic [DATA_WIDTH-1:0] p0_wdata,  p1_wdata;
  logic                  p0_gnt,    p1_gnt;
  logic                  p0_rvalid, p1_rvalid;
  logic [DATA_WIDTH-1:0] p0_rdata,  p1_rdata;

  logic                  CEN;
  logic                  WEN;
  logic [BE_WIDTH-1:0]   BEN;
  logic [ADDR_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] Q;

  modport slave (
    input  p0_req, p0_we, p0_be, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_be, p1_addr, p1_wdata,
    input  Q,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output CEN, WEN, BEN, A, D
  );

  modport master (
    output p0_req, p0_we, p0_be, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_be, p1_addr, p1_wdata,
    output Q,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  CEN, WEN, BEN, A, D
  );
endinterface

`default_nettype wire

// File: rtl/mem_bank_arbiter.sv
// Two-port arbiter in front of one single-port SRAM; response latency 1.
// MEM_ARB_ROUND_ROBIN_EN: defined = round-robin pointer, undefined = port 0 fixed priority.
`default_nettype none

module mem_bank_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic         CLK,
  input  wire logic         RST,
  mem_bank_arbiter_if.slave bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  prio;
  logic                  gnt0;
  logic                  gnt1;
  logic                  any_gnt;
  logic                  win_we;
  logic [BE_WIDTH-1:0]   win_be;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  logic                  resp_valid;
  logic                  resp_port;
  logic                  resp_is_read;

  // The priority pointer only matters when both ports request together.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!RST) begin
      if (bus.p0_req && (!bus.p1_req || !prio)) begin
        gnt0 = 1'b1;
      end else if (bus.p1_req) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign win_we    = gnt1 ? bus.p1_we    : bus.p0_we;
  assign win_be    = gnt1 ? bus.p1_be    : bus.p0_be;
  assign win_addr  = gnt1 ? bus.p1_addr  : bus.p0_addr;
  assign win_wdata = gnt1 ? bus.p1_wdata : bus.p0_wdata;

  assign bus.p0_gnt = gnt0;
  assign bus.p1_gnt = gnt1;

  assign bus.CEN = ~any_gnt;
  assign bus.WEN = any_gnt ? ~win_we : 1'b1;
  assign bus.BEN = any_gnt ? ~win_be : {BE_WIDTH{1'b1}};
  assign bus.A   = any_gnt ? win_addr  : '0;
  assign bus.D   = any_gnt ? win_wdata : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      resp_valid   <= 1'b0;
      resp_port    <= 1'b0;
      resp_is_read <= 1'b0;
    end else begin
      resp_valid   <= any_gnt;
      resp_port    <= gnt1;
      resp_is_read <= any_gnt & ~win_we;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      prio <= 1'b0;
    end else if (any_gnt) begin
      prio <= gnt0;
    end
  end
`else
  assign prio = 1'b0;
`endif

  // Responses follow the recorded port, not whoever is granted this cycle.
  assign bus.p0_rvalid = resp_valid & ~resp_port;
  assign bus.p1_rvalid = resp_valid &  resp_port;
  assign bus.p0_rdata  = (bus.p0_rvalid && resp_is_read) ? bus.Q : '0;
  assign bus.p1_rdata  = (bus.p1_rvalid && resp_is_read) ? bus.Q : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_bank_arbiter.sv
// Directed bench for mem_bank_arbiter with a behavioural single-port SRAM behind it.
`default_nettype none

module tb_mem_bank_arbiter;
  localparam int ADDR_WIDTH = 15;
  localparam int DATA_WIDTH = 32;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] mem [0:255];

  mem_bank_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  mem_bank_arbiter #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory: byte-masked write, registered read data one cycle after the access.
  always @(posedge clk) begin
    if (!bus.CEN) begin
      if (!bus.WEN) begin
        for (int b = 0; b < 4; b++)
          if (!bus.BEN[b]) mem[bus.A[7:0]][8*b +: 8] <= bus.D[8*b +: 8];
      end else begin
        bus.Q <= mem[bus.A[7:0]];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_p0(input logic req, input logic we, input logic [3:0] be,
                          input logic [14:0] addr, input logic [31:0] wdata);
    bus.p0_req = req; bus.p0_we = we; bus.p0_be = be; bus.p0_addr = addr; bus.p0_wdata = wdata;
  endtask

  task automatic drive_p1(input logic req, input logic we, input logic [3:0] be,
                          input logic [14:0] addr, input logic [31:0] wdata);
    bus.p1_req = req; bus.p1_we = we; bus.p1_be = be; bus.p1_addr = addr; bus.p1_wdata = wdata;
  endtask

  task automatic idle();
    drive_p0(1'b0, 1'b0, 4'h0, 15'h0, 32'h0);
    drive_p1(1'b0, 1'b0, 4'h0, 15'h0, 32'h0);
  endtask

  // Inputs change on the falling edge; checks run 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  logic prev_g0;

  initial begin
    idle();
    bus.Q = '0;
    drive_p0(1'b1, 1'b0, 4'hF, 15'h0010, 32'h0);

    // Reset with a pending request: nothing granted, memory idle.
    step(); step(); #1;
    check("rst_gnt0", bus.p0_gnt, 1'b0);
    check("rst_cen",  bus.CEN,    1'b1);
    check("rst_wen",  bus.WEN,    1'b1);
    check("rst_ben",  bus.BEN,    4'hF);
    check("rst_a",    bus.A,      15'h0);
    check("rst_rv",   {bus.p0_rvalid, bus.p1_rvalid}, 2'b00);
    check("rst_rd",   {bus.p0_rdata, bus.p1_rdata}, 64'h0);

    // Single write then read on p0.
    step(); rst = 1'b0;
    drive_p0(1'b1, 1'b1, 4'hF, 15'h0010, 32'hDEADBEEF); #1;
    check("wr_gnt0", bus.p0_gnt, 1'b1);
    check("wr_cen",  bus.CEN, 1'b0);
    check("wr_wen",  bus.WEN, 1'b0);
    check("wr_ben",  bus.BEN, 4'h0);
    check("wr_a",    bus.A, 15'h0010);
    check("wr_d",    bus.D, 32'hDEADBEEF);
    check("wr_rv0",  bus.p0_rvalid, 1'b0);
    step(); drive_p0(1'b1, 1'b0, 4'hF, 15'h0010, 32'h0); #1;
    check("rd_gnt0",   bus.p0_gnt, 1'b1);
    check("rd_wen",    bus.WEN, 1'b1);
    check("wresp_rv0", bus.p0_rvalid, 1'b1);
    check("wresp_rd0", bus.p0_rdata, 32'h0);
    step(); idle(); #1;
    check("rresp_rv0", bus.p0_rvalid, 1'b1);
    check("rresp_rd0", bus.p0_rdata, 32'hDEADBEEF);
    check("rresp_rv1", bus.p1_rvalid, 1'b0);
    check("rresp_cen", bus.CEN, 1'b1);
    step(); #1;
    check("rresp_done", {bus.p0_rvalid, bus.p1_rvalid}, 2'b00);
    check("rresp_rd0z", bus.p0_rdata, 32'h0);

    // Byte-masked write on p1.
    step(); drive_p1(1'b1, 1'b1, 4'hF, 15'h0020, 32'hFFFFFFFF); #1;
    check("bw1_gnt1", bus.p1_gnt, 1'b1);
    step(); drive_p1(1'b1, 1'b1, 4'h2, 15'h0020, 32'h0000AB00); #1;
    check("bw2_ben",  bus.BEN, 4'b1101);
    check("bw2_rv1",  bus.p1_rvalid, 1'b1);
    check("bw2_rd1",  bus.p1_rdata, 32'h0);
    step(); drive_p1(1'b1, 1'b0, 4'hF, 15'h0020, 32'h0); #1;
    check("bw3_gnt1", bus.p1_gnt, 1'b1);
    step(); idle(); #1;
    check("bw_rv1", bus.p1_rvalid, 1'b1);
    check("bw_rd1", bus.p1_rdata, 32'hFFFFABFF);
    check("bw_rv0", bus.p0_rvalid, 1'b0);

    // Contention from reset: both ports hold reads for 4 cycles.
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    prev_g0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      drive_p0(1'b1, 1'b0, 4'hF, 15'h0010, 32'h0);
      drive_p1(1'b1, 1'b0, 4'hF, 15'h0020, 32'h0);
      #1;
      check("ct_gnt0", bus.p0_gnt, RR ? (i % 2 == 0) : 1'b1);
      check("ct_gnt1", bus.p1_gnt, RR ? (i % 2 == 1) : 1'b0);
      check("ct_cen",  bus.CEN, 1'b0);
      if (i > 0) begin
        check("ct_rv0", bus.p0_rvalid, prev_g0);
        check("ct_rv1", bus.p1_rvalid, !prev_g0);
        check("ct_rd",  prev_g0 ? bus.p0_rdata : bus.p1_rdata,
                        prev_g0 ? 32'hDEADBEEF : 32'hFFFFABFF);
      end
      prev_g0 = RR ? (i % 2 == 0) : 1'b1;
    end
    step(); idle(); drive_p1(1'b1, 1'b0, 4'hF, 15'h0020, 32'h0); #1;
    check("ct_last_rv", {bus.p0_rvalid, bus.p1_rvalid}, RR ? 2'b01 : 2'b10);
    check("solo_gnt1",  bus.p1_gnt, 1'b1);

    // Reset mid-operation: pointer moved off port 0 first (round-robin build).
    step(); idle(); drive_p0(1'b1, 1'b1, 4'hF, 15'h0030, 32'h12345678); #1;
    check("pre_gnt0", bus.p0_gnt, 1'b1);
    step(); drive_p0(1'b1, 1'b0, 4'hF, 15'h0010, 32'h0); #1;
    check("mid_gnt0", bus.p0_gnt, 1'b1);
    #2 rst = 1'b1; #1;
    check("mid_gnt_rst", bus.p0_gnt, 1'b0);
    check("mid_cen_rst", bus.CEN, 1'b1);
    step(); idle(); #1;
    check("mid_drop_rv", {bus.p0_rvalid, bus.p1_rvalid}, 2'b00);
    check("mid_drop_rd", bus.p0_rdata, 32'h0);
    check("mid_cen",     bus.CEN, 1'b1);
    step(); rst = 1'b0;
    drive_p0(1'b1, 1'b0, 4'hF, 15'h0010, 32'h0);
    drive_p1(1'b1, 1'b0, 4'hF, 15'h0020, 32'h0); #1;
    check("ptr_gnt0", bus.p0_gnt, 1'b1);
    check("ptr_gnt1", bus.p1_gnt, 1'b0);
    step(); idle(); #1;
    check("ptr_rv0", bus.p0_rvalid, 1'b1);
    check("ptr_rd0", bus.p0_rdata, 32'hDEADBEEF);

    // Idle for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      step(); #1;
      check("idle_cen", bus.CEN, 1'b1);
      check("idle_ben", bus.BEN, 4'hF);
      check("idle_a",   bus.A, 15'h0);
      check("idle_d",   bus.D, 32'h0);
      check("idle_rv",  {bus.p0_rvalid, bus.p1_rvalid}, 2'b00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
